fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined 8-bit-instruction core. It owns the program counter, which drives the combinational instruction ROM/decoder. It captures the decoded instruction's PC into the IF/ID pipeline register, and handles stall, redirect/flush, halt and, optionally, early unconditional jumps. Downstream it feeds decode/execute; execute feeds taken-branch redirects back into it.

## Interface
Parameters:
- PC_W, 16, program-counter width (matches ROM `pc` input).
- CNT_W, 16, width of delivered-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  out  PC_W  current fetch address to instruction ROM.
- rom_opcode  in  4  opcode of instruction at `pc` (combinational from ROM).
- rom_jmp_loc  in  PC_W  jump-label target resolved by ROM for `pc`.
- stall_i  in  1  hazard unit: hold PC and IF/ID.
- redirect_i  in  1  execute: branch/jump taken, flush fetch.
- redirect_pc_i  in  PC_W  redirect target.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  PC_W  PC of instruction in IF/ID.
- ifid_pred_taken  out  1  instruction in IF/ID was a JMP already taken by fetch.
- halted  out  1  fetch is in HALTED state.
- fetch_count  out  CNT_W  instructions delivered to IF/ID; saturates at all-ones.

## Operation
- States: RUN, HALTED. Reset → RUN.
- Next-PC priority, evaluated each cycle:
  1. redirect_i: pc ← redirect_pc_i; ifid_valid ← 0; state ← RUN, including from HALTED.
  2. stall_i: pc, IF/ID, state and fetch_count all hold.
  3. HALTED: pc holds; ifid_valid ← 0.
  4. RUN with rom_opcode == HALT_OP (4'b1110): IF/ID captures the halt instruction (valid=1); pc holds; state ← HALTED.
  5. RUN with rom_opcode == JMP_OP (4'b0010) and JMP_EARLY_EN: IF/ID captures the JMP with ifid_pred_taken=1; pc ← rom_jmp_loc.
  6. Otherwise: IF/ID captures it (valid=1, ifid_pc ← pc, pred_taken=0); pc ← pc + 1.
- PC arithmetic is modulo 2^PC_W: 16'hFFFF + 1 → 16'h0000, with no flag.
- fetch_count increments on every cycle where IF/ID is loaded with valid=1. It does not increment on stall, flush or HALTED bubbles. At all-ones it holds.
- halted = (state == HALTED).
- A redirect arriving while HALTED means the halt was on a wrong path. Fetch resumes at redirect_pc_i.

## Timing
- Reset values: pc=0, ifid_valid=0, ifid_pc=0, ifid_pred_taken=0, halted=0, fetch_count=0, state=RUN.
- Fetch latency: pc presented in cycle N; ROM output captured into IF/ID at the end of N, so it is visible in N+1.
- Sequential fetch has throughput 1 instruction/cycle.
- Redirect costs one bubble: IF/ID is invalid in the cycle after redirect_i. The target is fetched that same cycle and is valid the cycle after.
- Early JMP has zero bubbles. Without JMP_EARLY_EN, a JMP costs whatever execute's redirect latency is.
- redirect_i and stall_i together: redirect wins.
- Reset asserted mid-operation forces all reset values immediately. The first fetch after release is pc=0.

## Configuration
- JMP_EARLY_EN defined: rule 5 active. ifid_pred_taken may be 1, and execute must suppress its own redirect for such JMPs.
- Not defined: rule 5 removed. A JMP fetches like any instruction (pc+1), and ifid_pred_taken is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants JMP_OP and HALT_OP (the full opcode list shared with the ROM);
  - the PC_W default;
  - the fetch state enum typedef.
- One sub-module, pc_next_sel: a purely combinational priority mux producing the next pc, the IF/ID load/valid controls and the next state. The top level holds only registers.

## Test plan
- Reset, then 4 cycles of non-branch opcodes (e.g. 4'b0100) → pc = 0,1,2,3,4; ifid_pc = 0,1,2,3; fetch_count = 4.
- stall_i high for 2 cycles at pc=5 → pc, ifid_pc and fetch_count frozen; fetch resumes at 5 with no skipped address.
- redirect_i with redirect_pc_i=16'h0040 while stall_i=1 → next pc=16'h0040, one invalid IF/ID cycle, then ifid_pc=16'h0040.
- HALT_OP at pc=7 → IF/ID holds pc 7 valid once; halted=1; pc stays 7; ifid_valid=0 thereafter. A later redirect to 16'h0010 → halted=0 and fetch resumes at 16'h0010.
- JMP_OP at pc=3 with rom_jmp_loc=10, with JMP_EARLY_EN → ifid_pc=3 with pred_taken=1, next pc=10, no bubble. Without JMP_EARLY_EN → next pc=4 and pred_taken=0.
- pc preset via redirect to 16'hFFFF, sequential fetch → next pc=16'h0000. fetch_count preloaded near all-ones saturates at 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage, the instruction ROM and
// the rest of the 8-bit-instruction core.
//   - opcode constants (4-bit opcode field of each instruction)
//   - default program-counter width
//   - fetch-stage state type
package cpu_pkg;

  localparam int PC_W_DEF = 16;

  // Opcode list shared with the ROM/decoder.
  localparam logic [3:0] NOP_OP  = 4'b0000;
  localparam logic [3:0] ADD_OP  = 4'b0001;
  localparam logic [3:0] JMP_OP  = 4'b0010;
  localparam logic [3:0] BEQ_OP  = 4'b0011;
  localparam logic [3:0] LDI_OP  = 4'b0100;
  localparam logic [3:0] HALT_OP = 4'b1110;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: signals between the fetch stage and its neighbours.
//   slave  : the fetch stage (drives pc and the IF/ID register outputs)
//   master : the environment (ROM, hazard unit, execute redirect)
// Signals:
//   pc, rom_opcode, rom_jmp_loc     - fetch address and combinational ROM reply
//   stall_i, redirect_i, redirect_pc_i - pipeline control into fetch
//   ifid_valid, ifid_pc, ifid_pred_taken - IF/ID register contents
//   halted, fetch_count             - status
interface fetch_stage_if #(
  parameter int PC_W  = cpu_pkg::PC_W_DEF,
  parameter int CNT_W = 16
);
  logic [PC_W-1:0]  pc;
  logic [3:0]       rom_opcode;
  logic [PC_W-1:0]  rom_jmp_loc;
  logic             stall_i;
  logic             redirect_i;
  logic [PC_W-1:0]  redirect_pc_i;
  logic             ifid_valid;
  logic [PC_W-1:0]  ifid_pc;
  logic             ifid_pred_taken;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  modport slave (
    output pc, ifid_valid, ifid_pc, ifid_pred_taken, halted, fetch_count,
    input  rom_opcode, rom_jmp_loc, stall_i, redirect_i, redirect_pc_i
  );

  modport master (
    input  pc, ifid_valid, ifid_pc, ifid_pred_taken, halted, fetch_count,
    output rom_opcode, rom_jmp_loc, stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-state logic of the fetch stage.
// Priority: redirect > stall > halted bubble > HALT capture > early JMP
// (only when JMP_EARLY_EN is defined) > sequential fetch.
// Inputs : current registers (state, pc, IF/ID, fetch count), ROM reply,
//          stall/redirect controls.
// Outputs: next values for every fetch-stage register.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = 16
) (
  input  fetch_state_e     state_q,
  input  logic [PC_W-1:0]  pc_q,
  input  logic             ifid_valid_q,
  input  logic [PC_W-1:0]  ifid_pc_q,
  input  logic             ifid_pred_taken_q,
  input  logic [CNT_W-1:0] fetch_count_q,
  input  logic [3:0]       rom_opcode,
  input  logic [PC_W-1:0]  rom_jmp_loc,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  output fetch_state_e     state_d,
  output logic [PC_W-1:0]  pc_d,
  output logic             ifid_valid_d,
  output logic [PC_W-1:0]  ifid_pc_d,
  output logic             ifid_pred_taken_d,
  output logic [CNT_W-1:0] fetch_count_d
);

`ifndef JMP_EARLY_EN
  // The jump target is only consumed by early jumps.
  logic unused_jmp_loc;
  assign unused_jmp_loc = ^rom_jmp_loc;
`endif

  logic load_ifid;

  always_comb begin
    // NOTE: every output gets a hold value first, so no path through the
    // priority chain can leave one unassigned and infer a latch.
    state_d           = state_q;
    pc_d              = pc_q;
    ifid_valid_d      = ifid_valid_q;
    ifid_pc_d         = ifid_pc_q;
    ifid_pred_taken_d = ifid_pred_taken_q;
    load_ifid         = 1'b0;

    if (redirect_i) begin
      // Also the way out of HALTED: the halt was on a wrong path.
      pc_d              = redirect_pc_i;
      ifid_valid_d      = 1'b0;
      ifid_pred_taken_d = 1'b0;
      state_d           = FETCH_RUN;
    end else if (stall_i) begin
      // hold everything
    end else if (state_q == FETCH_HALTED) begin
      ifid_valid_d      = 1'b0;
      ifid_pred_taken_d = 1'b0;
    end else begin
      load_ifid         = 1'b1;
      ifid_valid_d      = 1'b1;
      ifid_pc_d         = pc_q;
      ifid_pred_taken_d = 1'b0;
      if (rom_opcode == HALT_OP) begin
        state_d = FETCH_HALTED;
`ifdef JMP_EARLY_EN
      end else if (rom_opcode == JMP_OP) begin
        ifid_pred_taken_d = 1'b1;
        pc_d              = rom_jmp_loc;
`endif
      end else begin
        pc_d = pc_q + 1'b1;  // wraps modulo 2^PC_W
      end
    end

    fetch_count_d = fetch_count_q;
    if (load_ifid && (fetch_count_q != '1))
      fetch_count_d = fetch_count_q + 1'b1;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the program counter driving the
// combinational instruction ROM and the IF/ID pipeline register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - fetch_stage_if.slave (ROM, stall/redirect, IF/ID outputs, status)
// Build option: define JMP_EARLY_EN to let fetch take unconditional JMPs
// itself (ifid_pred_taken=1); otherwise a JMP is fetched like any other
// instruction and ifid_pred_taken stays 0.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  fetch_stage_if.slave bus
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic             ifid_pred_taken_q, ifid_pred_taken_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  pc_next_sel #(.PC_W(PC_W), .CNT_W(CNT_W)) u_sel (
    .state_q           (state_q),
    .pc_q              (pc_q),
    .ifid_valid_q      (ifid_valid_q),
    .ifid_pc_q         (ifid_pc_q),
    .ifid_pred_taken_q (ifid_pred_taken_q),
    .fetch_count_q     (fetch_count_q),
    .rom_opcode        (bus.rom_opcode),
    .rom_jmp_loc       (bus.rom_jmp_loc),
    .stall_i           (bus.stall_i),
    .redirect_i        (bus.redirect_i),
    .redirect_pc_i     (bus.redirect_pc_i),
    .state_d           (state_d),
    .pc_d              (pc_d),
    .ifid_valid_d      (ifid_valid_d),
    .ifid_pc_d         (ifid_pc_d),
    .ifid_pred_taken_d (ifid_pred_taken_d),
    .fetch_count_d     (fetch_count_d)
  );

  // NOTE: register updates use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= FETCH_RUN;
      pc_q              <= '0;
      ifid_valid_q      <= 1'b0;
      ifid_pc_q         <= '0;
      ifid_pred_taken_q <= 1'b0;
      fetch_count_q     <= '0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      ifid_valid_q      <= ifid_valid_d;
      ifid_pc_q         <= ifid_pc_d;
      ifid_pred_taken_q <= ifid_pred_taken_d;
      fetch_count_q     <= fetch_count_d;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.ifid_valid      = ifid_valid_q;
  assign bus.ifid_pc         = ifid_pc_q;
  assign bus.ifid_pred_taken = ifid_pred_taken_q;
  assign bus.halted          = (state_q == FETCH_HALTED);
  assign bus.fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test of fetch_stage with a behavioural reference
// model compared against the DUT every cycle, plus literal expectations.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.PC_W(16), .CNT_W(16)) bus ();

  fetch_stage #(.PC_W(16), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ROM program: a JMP and/or a HALT at chosen addresses, LDI elsewhere.
  logic        jmp_en = 1'b0, halt_en = 1'b0;
  logic [15:0] jmp_addr = '0, jmp_target = '0, halt_addr = '0;

  function automatic logic [3:0] rom_op(input logic [15:0] a);
    if (halt_en && a == halt_addr) return HALT_OP;
    if (jmp_en && a == jmp_addr) return JMP_OP;
    return LDI_OP;
  endfunction

  always_comb begin
    bus.rom_opcode  = LDI_OP;
    bus.rom_jmp_loc = jmp_target;
    if (halt_en && bus.pc == halt_addr)     bus.rom_opcode = HALT_OP;
    else if (jmp_en && bus.pc == jmp_addr)  bus.rom_opcode = JMP_OP;
  end

  logic        stall = 1'b0, redir = 1'b0;
  logic [15:0] redir_pc = '0;
  assign bus.stall_i       = stall;
  assign bus.redirect_i    = redir;
  assign bus.redirect_pc_i = redir_pc;

  // Reference model: fetch rules applied to plain integers.
  int m_pc = 0, m_ipc = 0, m_cnt = 0;
  bit m_v = 0, m_pred = 0, m_halt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_ipc <= 0; m_cnt <= 0; m_v <= 0; m_pred <= 0; m_halt <= 0;
    end else if (redir) begin
      m_pc <= int'(redir_pc); m_v <= 0; m_pred <= 0; m_halt <= 0;
    end else if (stall) begin
      // nothing changes
    end else if (m_halt) begin
      m_v <= 0; m_pred <= 0;
    end else begin
      m_v <= 1; m_ipc <= m_pc; m_pred <= 0;
      if (m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (rom_op(m_pc[15:0]) == HALT_OP) m_halt <= 1;
`ifdef JMP_EARLY_EN
      else if (rom_op(m_pc[15:0]) == JMP_OP) begin
        m_pred <= 1; m_pc <= int'(jmp_target);
      end
`endif
      else m_pc <= (m_pc + 1) % 65536;
    end
  end

  // Compare process: away from the active edge, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("pc", 32'(bus.pc), 32'(m_pc));
      check("ifid_valid", 32'(bus.ifid_valid), 32'(m_v));
      check("halted", 32'(bus.halted), 32'(m_halt));
      check("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
      if (m_v) begin
        check("ifid_pc", 32'(bus.ifid_pc), 32'(m_ipc));
        check("ifid_pred_taken", 32'(bus.ifid_pred_taken), 32'(m_pred));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_valid", 32'(bus.ifid_valid), 32'h0);
    check("rst_ifid_pc", 32'(bus.ifid_pc), 32'h0);
    check("rst_pred", 32'(bus.ifid_pred_taken), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_count", 32'(bus.fetch_count), 32'h0);
    rst_n = 1'b1;

    // Sequential fetch
    repeat (4) tick();
    check("seq_pc", 32'(bus.pc), 32'h4);
    check("seq_ifid_pc", 32'(bus.ifid_pc), 32'h3);
    check("seq_count", 32'(bus.fetch_count), 32'h4);
    tick();

    // Stall at pc=5
    stall = 1'b1;
    repeat (2) tick();
    check("stall_pc", 32'(bus.pc), 32'h5);
    check("stall_ifid_pc", 32'(bus.ifid_pc), 32'h4);
    check("stall_count", 32'(bus.fetch_count), 32'h5);
    stall = 1'b0;
    tick();
    check("resume_ifid_pc", 32'(bus.ifid_pc), 32'h5);
    check("resume_pc", 32'(bus.pc), 32'h6);

    // Redirect wins over stall
    stall = 1'b1; redir = 1'b1; redir_pc = 16'h0040;
    tick();
    check("redir_pc", 32'(bus.pc), 32'h40);
    check("redir_bubble", 32'(bus.ifid_valid), 32'h0);
    stall = 1'b0; redir = 1'b0;
    tick();
    check("redir_tgt_valid", 32'(bus.ifid_valid), 32'h1);
    check("redir_tgt_pc", 32'(bus.ifid_pc), 32'h40);
    check("redir_count", 32'(bus.fetch_count), 32'h7);

    // HALT at pc=7, then escape by redirect
    halt_en = 1'b1; halt_addr = 16'h0007;
    redir = 1'b1; redir_pc = 16'h0007;
    tick();
    redir = 1'b0;
    tick();
    check("halt_ifid_pc", 32'(bus.ifid_pc), 32'h7);
    check("halt_valid", 32'(bus.ifid_valid), 32'h1);
    check("halt_halted", 32'(bus.halted), 32'h1);
    check("halt_pc", 32'(bus.pc), 32'h7);
    tick();
    check("halted_bubble", 32'(bus.ifid_valid), 32'h0);
    check("halted_pc", 32'(bus.pc), 32'h7);
    check("halted_count", 32'(bus.fetch_count), 32'h8);
    redir = 1'b1; redir_pc = 16'h0010;
    tick();
    redir = 1'b0; halt_en = 1'b0;
    check("unhalt", 32'(bus.halted), 32'h0);
    check("unhalt_pc", 32'(bus.pc), 32'h10);

    // JMP at pc=3 targeting 10
    jmp_en = 1'b1; jmp_addr = 16'h0003; jmp_target = 16'h000A;
    redir = 1'b1; redir_pc = 16'h0003;
    tick();
    redir = 1'b0;
    tick();
    check("jmp_ifid_pc", 32'(bus.ifid_pc), 32'h3);
    check("jmp_count", 32'(bus.fetch_count), 32'h9);
`ifdef JMP_EARLY_EN
    check("jmp_pred", 32'(bus.ifid_pred_taken), 32'h1);
    check("jmp_next_pc", 32'(bus.pc), 32'hA);
`else
    check("jmp_pred", 32'(bus.ifid_pred_taken), 32'h0);
    check("jmp_next_pc", 32'(bus.pc), 32'h4);
`endif
    tick();
    check("jmp_no_bubble", 32'(bus.ifid_valid), 32'h1);
    jmp_en = 1'b0;

    // PC wrap
    redir = 1'b1; redir_pc = 16'hFFFF;
    tick();
    redir = 1'b0;
    check("wrap_pre", 32'(bus.pc), 32'hFFFF);
    tick();
    check("wrap_pc", 32'(bus.pc), 32'h0);
    check("wrap_ifid_pc", 32'(bus.ifid_pc), 32'hFFFF);

    // Asynchronous reset mid-operation
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(bus.pc), 32'h0);
    check("arst_valid", 32'(bus.ifid_valid), 32'h0);
    check("arst_count", 32'(bus.fetch_count), 32'h0);
    check("arst_halted", 32'(bus.halted), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ifid_pc", 32'(bus.ifid_pc), 32'h0);
    check("post_rst_pc", 32'(bus.pc), 32'h1);

    // Counter saturation
    repeat (65540) @(posedge clk);
    #2;
    check("count_sat", 32'(bus.fetch_count), 32'hFFFF);
    tick();
    check("count_sat_hold", 32'(bus.fetch_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
